aes_spi_frontend: RTL and testbench

Parametrised next-generation SPI front-end for the AES accelerator. All SPI signals are sampled in the system clock domain, so there is no SPI-clock domain logic. A command byte selects one of four frame types: load key, load plaintext and start, read cyphertext, or read status. Key width is configurable. The block sits between the Raspberry Pi SPI master and the AES core: it drives key/plaintext/start to the core and captures the core's result.

---
 rtl/aes_spi_frontend_if.sv | 20 ++
 rtl/aes_spi_frontend.sv | 250 +++++++++++++++++++++++++
 tb/tb_aes_spi_frontend.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/aes_spi_frontend_if.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_frontend_if
// Purpose  : SPI bus between the Raspberry Pi master and the AES front-end.
// Signals  : r_sclk  - SPI clock, mode 0 (master -> slave)
//            r_mosi  - serial data in, MSB first (master -> slave)
//            r_ce    - frame enable, active-high (master -> slave)
//            r_miso  - serial data out, MSB first (slave -> master)
// Revision : 1.0 - initial release
// ============================================================================
interface aes_spi_frontend_if;
    logic r_sclk;
    logic r_mosi;
    logic r_ce;
    logic r_miso;

    modport master (output r_sclk, output r_mosi, output r_ce, input r_miso);
    modport slave  (input r_sclk, input r_mosi, input r_ce, output r_miso);
endinterface
`default_nettype wire

// File: rtl/aes_spi_frontend.sv
`default_nettype none
// ============================================================================
// Module   : aes_spi_frontend
// Purpose  : SPI command front-end for the AES accelerator. All SPI lines are
//            oversampled in the clk domain. A command byte selects load key
//            (0x01), load plaintext + start (0x02), read cyphertext (0x03) or
//            read status (0x04).
// Ports    : clk, reset_n       - system clock, async active-low reset
//            spi (slave)        - r_sclk / r_mosi / r_ce in, r_miso out
//            key, plaintext     - registers driven to the AES core
//            start              - one-cycle encryption start pulse
//            core_busy          - core is encrypting
//            core_done          - one-cycle pulse, cyphertext valid
//            cyphertext         - core result
//            done               - result held, no newer start issued
// Revision : 1.0 - initial release
// ============================================================================
module aes_spi_frontend #(
    parameter int KEY_BITS    = 128,
    parameter int SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                reset_n,
    aes_spi_frontend_if.slave   spi,
    output logic [KEY_BITS-1:0] key,
    output logic [127:0]        plaintext,
    output logic                start,
    input  logic                core_busy,
    input  logic                core_done,
    input  logic [127:0]        cyphertext,
    output logic                done
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CMD    = 3'd1,
        ST_KEY_RX = 3'd2,
        ST_PT_RX  = 3'd3,
        ST_CT_TX  = 3'd4,
        ST_ST_TX  = 3'd5,
        ST_IGNORE = 3'd6
    } state_t;

    localparam logic [8:0] C_LAST_BYTE = 9'd7;
    localparam logic [8:0] C_LAST_BLK  = 9'd127;
    localparam logic [8:0] C_LAST_KEY  = 9'(KEY_BITS - 1);

    // ------------------------------------------------------------------
    // Reset: asserted asynchronously, released on a clock edge
    // ------------------------------------------------------------------
    logic [1:0] rst_sync_q;
    logic       w_rst_n;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) rst_sync_q <= 2'b00;
        else          rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign w_rst_n = rst_sync_q[1];

    // ------------------------------------------------------------------
    // Input synchronisers; bit 0 is the newest sample
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sclk_sync_q;
    logic [SYNC_STAGES-1:0] mosi_sync_q;
    logic [SYNC_STAGES-1:0] ce_sync_q;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            sclk_sync_q <= '0;
            mosi_sync_q <= '0;
            ce_sync_q   <= '0;
        end else begin
            sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi.r_sclk};
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi.r_mosi};
            ce_sync_q   <= {ce_sync_q[SYNC_STAGES-2:0], spi.r_ce};
        end
    end

    logic w_sclk_rise, w_sclk_fall, w_ce_rise, w_ce_fall, w_mosi;
    assign w_sclk_rise =  sclk_sync_q[SYNC_STAGES-2] & ~sclk_sync_q[SYNC_STAGES-1];
    assign w_sclk_fall = ~sclk_sync_q[SYNC_STAGES-2] &  sclk_sync_q[SYNC_STAGES-1];
    assign w_ce_rise   =  ce_sync_q[SYNC_STAGES-2]   & ~ce_sync_q[SYNC_STAGES-1];
    assign w_ce_fall   = ~ce_sync_q[SYNC_STAGES-2]   &  ce_sync_q[SYNC_STAGES-1];
    // Oldest mosi sample: data has been stable since the previous sclk fall,
    // which is many clk cycles earlier given the clk/8 sclk limit.
    assign w_mosi      = mosi_sync_q[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t              state_q, state_d;
    logic [8:0]          cnt_q, cnt_d;
    logic [KEY_BITS-1:0] rx_q, rx_d;
    logic [127:0]        tx_q, tx_d;
    logic                miso_q, miso_d;
    logic [KEY_BITS-1:0] key_q, key_d;
    logic [127:0]        pt_q, pt_d;
    logic [127:0]        ct_q, ct_d;
    logic                start_q, start_d;
    logic                done_q, done_d;
    logic                key_valid_q, key_valid_d;
    logic                ct_valid_q, ct_valid_d;
    logic                err_q, err_d;

    always_ff @(posedge clk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            rx_q        <= '0;
            tx_q        <= '0;
            miso_q      <= 1'b0;
            key_q       <= '0;
            pt_q        <= '0;
            ct_q        <= '0;
            start_q     <= 1'b0;
            done_q      <= 1'b0;
            key_valid_q <= 1'b0;
            ct_valid_q  <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rx_q        <= rx_d;
            tx_q        <= tx_d;
            miso_q      <= miso_d;
            key_q       <= key_d;
            pt_q        <= pt_d;
            ct_q        <= ct_d;
            start_q     <= start_d;
            done_q      <= done_d;
            key_valid_q <= key_valid_d;
            ct_valid_q  <= ct_valid_d;
            err_q       <= err_d;
        end
    end

    // One shifter serves both the command byte (low 8 bits) and the payload.
    logic [KEY_BITS-1:0] w_rx_shift;
    assign w_rx_shift = {rx_q[KEY_BITS-2:0], w_mosi};

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rx_d        = rx_q;
        tx_d        = tx_q;
        miso_d      = miso_q;
        key_d       = key_q;
        pt_d        = pt_q;
        ct_d        = ct_q;
        start_d     = 1'b0;
        done_d      = done_q;
        key_valid_d = key_valid_q;
        ct_valid_d  = ct_valid_q;
        err_d       = err_q;

        if (w_sclk_rise) begin
            rx_d  = w_rx_shift;
            cnt_d = cnt_q + 9'd1;
        end

        if (w_sclk_fall && (state_q == ST_CT_TX || state_q == ST_ST_TX)) begin
            miso_d = tx_q[127];
            tx_d   = {tx_q[126:0], 1'b0};
        end

        // Capture runs regardless of the SPI state; a CT_TX in flight keeps
        // shifting its own snapshot in tx_q.
        if (core_done) begin
            ct_d       = cyphertext;
            ct_valid_d = 1'b1;
            done_d     = 1'b1;
        end

        if (w_ce_fall) begin
            // Abort has priority over any commit on the same strobe.
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (w_ce_rise) state_d = ST_CMD;
                end
                ST_CMD: begin
                    if (w_sclk_rise && cnt_q == C_LAST_BYTE) begin
                        case (w_rx_shift[7:0])
                            8'h01: state_d = ST_KEY_RX;
                            8'h02: state_d = ST_PT_RX;
                            8'h03: begin
                                state_d = ST_CT_TX;
                                tx_d    = ct_q;
                            end
                            8'h04: begin
                                state_d = ST_ST_TX;
                                // Registered flags: a same-cycle capture is
                                // not yet visible here.
                                tx_d    = {4'b0000, err_q, core_busy, ct_valid_q,
                                           key_valid_q, 120'd0};
                                err_d   = 1'b0;
                            end
                            default: begin
                                state_d = ST_IGNORE;
                                err_d   = 1'b1;
                            end
                        endcase
                    end
                end
                ST_KEY_RX: begin
                    if (w_sclk_rise && cnt_q == C_LAST_KEY) begin
                        key_d       = w_rx_shift;
                        key_valid_d = 1'b1;
                        state_d     = ST_IGNORE;
                    end
                end
                ST_PT_RX: begin
                    if (w_sclk_rise && cnt_q == C_LAST_BLK) begin
                        if (key_valid_q && !core_busy) begin
                            pt_d       = w_rx_shift[127:0];
                            start_d    = 1'b1;
                            done_d     = 1'b0;
                            ct_valid_d = 1'b0;
                        end else begin
                            err_d = 1'b1;
                        end
                        state_d = ST_IGNORE;
                    end
                end
                // Leave a TX state only after the master has sampled the last
                // bit, i.e. on the rising strobe that follows the final shift.
                ST_CT_TX: begin
                    if (w_sclk_rise && cnt_q == C_LAST_BLK) state_d = ST_IGNORE;
                end
                ST_ST_TX: begin
                    if (w_sclk_rise && cnt_q == C_LAST_BYTE) state_d = ST_IGNORE;
                end
                default: ;
            endcase
        end

        if (state_d != state_q) cnt_d = '0;

        if (state_d != ST_CT_TX && state_d != ST_ST_TX) miso_d = 1'b0;
    end

    assign spi.r_miso = miso_q;
    assign key        = key_q;
    assign plaintext  = pt_q;
    assign start      = start_q;
    assign done       = done_q;

endmodule
`default_nettype wire

// File: tb/tb_aes_spi_frontend.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_spi_frontend
// Purpose  : Self-checking bench for aes_spi_frontend. DUT A uses a 128-bit
//            key with a small core model; DUT B uses a 256-bit key. A frame
//            table drives both, followed by a hand-written simultaneous
//            abort/last-bit sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_spi_frontend;

    localparam int HALF = 80;
    localparam logic [127:0] KA  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [255:0] KB1 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    localparam logic [255:0] KB2 = 256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset_n;
    logic sel;
    logic sclk, mosi, ce;
    logic miso;

    aes_spi_frontend_if if_a();
    aes_spi_frontend_if if_b();

    assign if_a.r_sclk = (sel == 1'b0) ? sclk : 1'b0;
    assign if_a.r_mosi = (sel == 1'b0) ? mosi : 1'b0;
    assign if_a.r_ce   = (sel == 1'b0) ? ce   : 1'b0;
    assign if_b.r_sclk = (sel == 1'b1) ? sclk : 1'b0;
    assign if_b.r_mosi = (sel == 1'b1) ? mosi : 1'b0;
    assign if_b.r_ce   = (sel == 1'b1) ? ce   : 1'b0;
    assign miso        = sel ? if_b.r_miso : if_a.r_miso;

    logic [127:0] key_a, pt_a, ct_in_a;
    logic         start_a, done_a, busy_a, core_done_a;
    logic         model_busy, force_busy;
    logic [255:0] key_b;
    logic [127:0] pt_b;
    logic         start_b, done_b;
    logic         tie0;
    logic [127:0] tie0_128;

    assign busy_a   = model_busy | force_busy;
    assign tie0     = 1'b0;
    assign tie0_128 = '0;

    aes_spi_frontend #(.KEY_BITS(128), .SYNC_STAGES(2)) dut_a (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi        (if_a),
        .key        (key_a),
        .plaintext  (pt_a),
        .start      (start_a),
        .core_busy  (busy_a),
        .core_done  (core_done_a),
        .cyphertext (ct_in_a),
        .done       (done_a)
    );

    aes_spi_frontend #(.KEY_BITS(256), .SYNC_STAGES(3)) dut_b (
        .clk        (clk),
        .reset_n    (reset_n),
        .spi        (if_b),
        .key        (key_b),
        .plaintext  (pt_b),
        .start      (start_b),
        .core_busy  (tie0),
        .core_done  (tie0),
        .cyphertext (tie0_128),
        .done       (done_b)
    );

    // Start pulses are counted on every clk cycle they are high, so a
    // stretched pulse shows up as an extra count.
    int start_cnt_a = 0;
    int start_cnt_b = 0;
    initial forever begin
        @(negedge clk);
        if (start_a === 1'b1) start_cnt_a++;
        if (start_b === 1'b1) start_cnt_b++;
    end

    // Core model for DUT A: busy for 10 cycles after start, then a result.
    initial begin
        model_busy  = 1'b0;
        core_done_a = 1'b0;
        ct_in_a     = '0;
        forever begin
            @(negedge clk);
            if (start_a === 1'b1) begin
                model_busy = 1'b1;
                repeat (10) @(negedge clk);
                ct_in_a     = CT;
                core_done_a = 1'b1;
                @(negedge clk);
                core_done_a = 1'b0;
                model_busy  = 1'b0;
            end
        end
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h want %0h", name, act, exp);
        else             n_pass++;
    endtask

    // One frame: command byte plus nbytes payload bytes taken MSB-first from
    // the top of data. The first 16 payload bytes seen on miso go to resp.
    // abort_last drops ce together with the final sclk rise.
    task automatic spi_frame(input logic [7:0] cmd, input int nbytes,
                             input logic [263:0] data, input bit abort_last,
                             output logic [127:0] resp);
        logic [7:0] b;
        resp = '0;
        ce   = 1'b1;
        #200;
        for (int i = -1; i < nbytes; i++) begin
            b = (i < 0) ? cmd : data[263 - 8*i -: 8];
            for (int k = 7; k >= 0; k--) begin
                mosi = b[k];
                #HALF;
                if (i >= 0 && i < 16) resp[127 - 8*i - 7 + k] = miso;
                sclk = 1'b1;
                if (abort_last && i == nbytes - 1 && k == 0) ce = 1'b0;
                #HALF;
                sclk = 1'b0;
            end
        end
        #200;
        ce = 1'b0;
        #300;
    endtask

    typedef struct {
        bit           sel;
        logic [7:0]   cmd;
        int           nbytes;
        logic [263:0] data;
        bit           busy;
        logic [127:0] exp_resp;
        logic [255:0] exp_key;
        logic [127:0] exp_pt;
        int           exp_starts;
        logic         exp_done;
    } vec_t;

    vec_t         vec [16];
    logic [127:0] resp;

    initial begin
        reset_n    = 1'b0;
        sel        = 1'b0;
        sclk       = 1'b0;
        mosi       = 1'b0;
        ce         = 1'b0;
        force_busy = 1'b0;
        #100;
        reset_n = 1'b1;
        #100;

        chk("reset key_a",   {128'd0, key_a}, 256'd0);
        chk("reset pt_a",    {128'd0, pt_a},  256'd0);
        chk("reset start_a", {255'd0, start_a}, 256'd0);
        chk("reset done_a",  {255'd0, done_a},  256'd0);
        chk("reset miso_a",  {255'd0, if_a.r_miso}, 256'd0);
        chk("reset key_b",   key_b, 256'd0);

        //            sel   cmd    n   data                                   busy resp                 key              pt     st done
        vec[0]  = '{1'b0, 8'h04, 1,  264'd0,                                 1'b0, 128'd0,              256'd0,          128'd0, 0, 1'b0};
        vec[1]  = '{1'b0, 8'h02, 16, {PT, 136'd0},                           1'b0, 128'd0,              256'd0,          128'd0, 0, 1'b0};
        vec[2]  = '{1'b0, 8'h04, 1,  264'd0,                                 1'b0, {8'h08, 120'd0},     256'd0,          128'd0, 0, 1'b0};
        vec[3]  = '{1'b0, 8'h04, 1,  264'd0,                                 1'b0, 128'd0,              256'd0,          128'd0, 0, 1'b0};
        vec[4]  = '{1'b0, 8'h01, 16, {KA, 136'd0},                           1'b0, 128'd0,              {128'd0, KA},    128'd0, 0, 1'b0};
        vec[5]  = '{1'b0, 8'h01, 5,  {40'haabbccddee, 224'd0},               1'b0, 128'd0,              {128'd0, KA},    128'd0, 0, 1'b0};
        vec[6]  = '{1'b0, 8'h7e, 4,  {32'hffffffff, 232'd0},                 1'b0, 128'd0,              {128'd0, KA},    128'd0, 0, 1'b0};
        vec[7]  = '{1'b0, 8'h04, 1,  264'd0,                                 1'b0, {8'h09, 120'd0},     {128'd0, KA},    128'd0, 0, 1'b0};
        vec[8]  = '{1'b0, 8'h02, 16, {PT, 136'd0},                           1'b1, 128'd0,              {128'd0, KA},    128'd0, 0, 1'b0};
        vec[9]  = '{1'b0, 8'h04, 1,  264'd0,                                 1'b1, {8'h0d, 120'd0},     {128'd0, KA},    128'd0, 0, 1'b0};
        vec[10] = '{1'b0, 8'h02, 16, {PT, 136'd0},                           1'b0, 128'd0,              {128'd0, KA},    PT,     1, 1'b1};
        vec[11] = '{1'b0, 8'h04, 1,  264'd0,                                 1'b0, {8'h03, 120'd0},     {128'd0, KA},    PT,     1, 1'b1};
        vec[12] = '{1'b0, 8'h03, 16, 264'd0,                                 1'b0, CT,                  {128'd0, KA},    PT,     1, 1'b1};
        vec[13] = '{1'b1, 8'h01, 32, {KB1, 8'd0},                            1'b0, 128'd0,              KB1,             128'd0, 0, 1'b0};
        vec[14] = '{1'b1, 8'h01, 33, {KB2, 8'h40},                           1'b0, 128'd0,              KB2,             128'd0, 0, 1'b0};
        vec[15] = '{1'b1, 8'h01, 31, {248'h808182838485868788898a8b8c8d8e8f909192939495969798999a9b9c9d9e, 16'd0},
                                                                              1'b0, 128'd0,              KB2,             128'd0, 0, 1'b0};

        for (int i = 0; i < 16; i++) begin
            sel        = vec[i].sel;
            force_busy = vec[i].busy;
            spi_frame(vec[i].cmd, vec[i].nbytes, vec[i].data, 1'b0, resp);
            #600;
            chk($sformatf("v%0d resp", i), {128'd0, resp}, {128'd0, vec[i].exp_resp});
            chk($sformatf("v%0d key", i),
                sel ? key_b : {128'd0, key_a}, vec[i].exp_key);
            chk($sformatf("v%0d plaintext", i),
                {128'd0, sel ? pt_b : pt_a}, {128'd0, vec[i].exp_pt});
            chk($sformatf("v%0d starts", i),
                256'(sel ? start_cnt_b : start_cnt_a), 256'(vec[i].exp_starts));
            chk($sformatf("v%0d done", i),
                {255'd0, sel ? done_b : done_a}, {255'd0, vec[i].exp_done});
            force_busy = 1'b0;
        end

        // ce falls on the same strobe as the final key bit: nothing commits.
        sel = 1'b0;
        spi_frame(8'h01, 16, {128'hffffffffffffffffffffffffffffffff, 136'd0}, 1'b1, resp);
        #600;
        chk("abort last bit key", {128'd0, key_a}, {128'd0, KA});
        spi_frame(8'h04, 1, 264'd0, 1'b0, resp);
        #600;
        chk("abort last bit status", {128'd0, resp}, {128'd0, 8'h03, 120'd0});
        chk("abort last bit starts", 256'(start_cnt_a), 256'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
